// File: rtl/rip_ro_pkg.sv
// Shared types and width helpers for the ring-oscillator measurement controller.
package rip_ro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT
  } ro_state_e;

  function automatic int idx_width(input int num_ro);
    return (num_ro > 1) ? $clog2(num_ro) : 1;
  endfunction

  // One timer serves both phases, so it is sized for the longer one.
  function automatic int timer_width(input int window_cycles, input int settle_cycles);
    return $clog2(((window_cycles > settle_cycles) ? window_cycles : settle_cycles) + 1);
  endfunction

endpackage

// File: rtl/rip_ro_edge_counter.sv
// Synchronises every oscillator output, detects rising edges on the selected one
// and counts them with saturation; next-state values include the current cycle's edge.
module rip_ro_edge_counter
  import rip_ro_pkg::*;
#(
  parameter int NUM_RO = 4,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_RO-1:0] ro_in,
  input  logic [IDX_W-1:0]  sel,
  input  logic              clear,
  input  logic              enable,
  output logic [CNT_W-1:0]  count_next,
  output logic              sat_next
);

  logic [NUM_RO-1:0] sync1, sync2, sync3;
  logic [NUM_RO-1:0] sel_mask;
  logic [CNT_W-1:0]  count;
  logic              sat;
  logic              rise;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // A mask rather than a bit-select keeps the single-oscillator case well formed.
  assign sel_mask = NUM_RO'(1) << sel;
  assign rise     = |(sync2 & ~sync3 & sel_mask);

  always_comb begin
    count_next = count;
    sat_next   = sat;
    if (clear) begin
      count_next = '0;
      sat_next   = 1'b0;
    end else if (enable && rise && !(&count)) begin
      count_next = count + CNT_W'(1);
      if (&count_next) sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= count_next;
      sat   <= sat_next;
    end
  end

endmodule

// File: rtl/rip_ro_controller.sv
// Steps through the oscillator bank one at a time: settle, count edges over a
// fixed window, then hold the result until the consumer takes it.
module rip_ro_controller
  import rip_ro_pkg::*;
#(
  parameter int NUM_RO        = 4,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  localparam int IDX_W        = idx_width(NUM_RO)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              continuous,
  output logic [NUM_RO-1:0] ro_rstn,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [IDX_W-1:0]  result_idx,
  output logic [CNT_W-1:0]  result_count,
  output logic              result_sat
);

  localparam int TMR_W = timer_width(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_RO - 1);

  ro_state_e        state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             latch, cnt_clear, cnt_enable;
  logic [CNT_W-1:0] count_next;
  logic             sat_next;

  rip_ro_edge_counter #(
    .NUM_RO (NUM_RO),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_edge_counter (
    .clk        (clk),
    .rstn       (rstn),
    .ro_in      (ro_in),
    .sel        (idx),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .count_next (count_next),
    .sat_next   (sat_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      timer <= timer_nxt;
    end
  end

  // The window's last cycle latches count_next so an edge seen in that cycle is kept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_idx   <= '0;
      result_count <= '0;
      result_sat   <= 1'b0;
    end else if (latch) begin
      result_idx   <= idx;
      result_count <= count_next;
      result_sat   <= sat_next;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    timer_nxt  = timer;
    latch      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          idx_nxt   = '0;
          timer_nxt = '0;
        end
      end
      SETTLE: begin
        cnt_clear = 1'b1;
        if (timer == SETTLE_LAST) begin
          state_nxt = MEASURE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      MEASURE: begin
        cnt_enable = 1'b1;
        if (timer == WINDOW_LAST) begin
          latch     = 1'b1;
          state_nxt = REPORT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      REPORT: begin
        if (result_ready) begin
          timer_nxt = '0;
          if (idx < IDX_LAST) begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = SETTLE;
          end else if (continuous) begin
            idx_nxt   = '0;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded straight from the state flops so reset stops the oscillator without a clock.
  assign ro_rstn      = ((state == SETTLE) || (state == MEASURE)) ? (NUM_RO'(1) << idx) : '0;
  assign busy         = (state != IDLE);
  assign result_valid = (state == REPORT);

endmodule

// File: tb/tb_rip_ro_controller.sv
// Scoreboard bench for rip_ro_controller: oscillators modelled as clk-synchronous
// toggles, expected results queued at start and popped on each handshake.
module tb_rip_ro_controller;

  localparam int NUM_RO = 2;
  localparam int WINDOW = 64;
  localparam int SETTLE = 4;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  typedef struct {
    int idx;
    int count;
    int sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic              result_ready = 1'b1;
  logic [NUM_RO-1:0] ro_rstn;
  logic [NUM_RO-1:0] ro_in;
  logic              busy;
  logic              result_valid;
  logic [0:0]        result_idx;
  logic [CNT_W-1:0]  result_count;
  logic              result_sat;

  int   half_per[NUM_RO];
  int   checks = 0;
  int   passed = 0;
  int   results_seen = 0;
  int   onehot_viol = 0;
  exp_t sb[$];

  rip_ro_controller #(
    .NUM_RO        (NUM_RO),
    .WINDOW_CYCLES (WINDOW),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .continuous   (continuous),
    .ro_rstn      (ro_rstn),
    .ro_in        (ro_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_idx   (result_idx),
    .result_count (result_count),
    .result_sat   (result_sat)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge, well clear of sampling.
  task automatic applyStimulus(input logic st, input logic cont, input logic rdy);
    @(posedge clk);
    #1;
    start        = st;
    continuous   = cont;
    result_ready = rdy;
  endtask

  // Oscillator i toggles every half_per[i] enabled cycles, starting from the first
  // enabled cycle; its first rise comes at enabled negedge m = half-1, then every
  // 2*half. A rise at enabled negedge m is counted when m+2 falls inside the window,
  // i.e. SETTLE-2 <= m <= SETTLE+WINDOW-3.
  function automatic exp_t expected(input int idx, input int half);
    exp_t e;
    int raw = 0;
    for (int m = half - 1; m <= SETTLE + WINDOW - 3; m += 2 * half)
      if (m >= SETTLE - 2) raw++;
    e.idx   = idx;
    e.count = (raw > MAXC) ? MAXC : raw;
    e.sat   = (raw >= MAXC) ? 1 : 0;
    return e;
  endfunction

  task automatic pushScan();
    for (int i = 0; i < NUM_RO; i++) sb.push_back(expected(i, half_per[i]));
  endtask

  task automatic pulseStart(input logic cont);
    applyStimulus(1'b1, cont, 1'b1);
    applyStimulus(1'b0, cont, 1'b1);
  endtask

  task automatic waitIdle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("idle_reached", busy, 0);
  endtask

  task automatic waitResults(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (results_seen >= target) break;
    end
    checkOutput("result_count_reached", results_seen, target);
  endtask

  initial begin : ro_model
    int cnt[NUM_RO];
    ro_in = '0;
    for (int i = 0; i < NUM_RO; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_RO; i++) begin
        if (!ro_rstn[i]) begin
          cnt[i]   = 0;
          ro_in[i] = 1'b0;
        end else begin
          cnt[i]++;
          if (cnt[i] >= half_per[i]) begin
            cnt[i]   = 0;
            ro_in[i] = ~ro_in[i];
          end
        end
      end
      if ($countones(ro_rstn) > 1) onehot_viol++;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && result_valid && result_ready) begin
        results_seen++;
        checkOutput("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("res_idx", result_idx, e.idx);
          checkOutput("res_count", result_count, e.count);
          checkOutput("res_sat", result_sat, e.sat);
        end
      end
    end
  end

  initial begin : main
    int lat;
    int base;
    logic [CNT_W-1:0] hold_count;
    logic [0:0] hold_idx;
    logic hold_sat;
    logic stable, ro_off, valid_held;

    half_per[0] = 4;
    half_per[1] = 8;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ro_rstn", ro_rstn, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", result_valid, 0);
    checkOutput("rst_idx", result_idx, 0);
    checkOutput("rst_count", result_count, 0);
    checkOutput("rst_sat", result_sat, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Basic scan with latency measurement
    pushScan();
    lat = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      if (result_valid) begin
        lat = n;
        break;
      end
    end
    checkOutput("latency", lat, 1 + SETTLE + WINDOW);
    waitIdle(400);
    checkOutput("t1_sb_drained", sb.size(), 0);
    checkOutput("t1_results", results_seen, 2);

    // Backpressure on the first result
    base = results_seen;
    pushScan();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    checkOutput("bp_valid", result_valid, 1);
    hold_idx   = result_idx;
    hold_count = result_count;
    hold_sat   = result_sat;
    stable = 1'b1;
    ro_off = 1'b1;
    valid_held = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (result_idx !== hold_idx || result_count !== hold_count || result_sat !== hold_sat)
        stable = 1'b0;
      if (ro_rstn !== '0) ro_off = 1'b0;
      if (!result_valid) valid_held = 1'b0;
    end
    checkOutput("bp_stable", stable, 1);
    checkOutput("bp_ro_off", ro_off, 1);
    checkOutput("bp_valid_held", valid_held, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_hs_ro_off", ro_rstn, 0);
    @(negedge clk);
    checkOutput("bp_next_ro", ro_rstn, 2'b10);
    checkOutput("bp_valid_fell", result_valid, 0);
    waitIdle(400);
    checkOutput("t2_sb_drained", sb.size(), 0);
    checkOutput("t2_results", results_seen, base + 2);

    // Saturation
    half_per[0] = 1;
    half_per[1] = 1;
    base = results_seen;
    pushScan();
    pulseStart(1'b0);
    waitIdle(400);
    checkOutput("t3_sb_drained", sb.size(), 0);
    checkOutput("t3_results", results_seen, base + 2);

    // Continuous mode, dropped during the second idx0 window
    half_per[0] = 4;
    half_per[1] = 8;
    base = results_seen;
    pushScan();
    pushScan();
    pulseStart(1'b1);
    waitResults(base + 2, 400);
    repeat (20) @(negedge clk);
    checkOutput("cont_in_measure", ro_rstn, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitIdle(400);
    checkOutput("t4_sb_drained", sb.size(), 0);
    checkOutput("t4_results", results_seen, base + 4);

    // Reset mid-window
    base = results_seen;
    pulseStart(1'b0);
    repeat (SETTLE + 20) @(posedge clk);
    #2;
    checkOutput("rm_measuring", ro_rstn, 2'b01);
    #1 rstn = 1'b0;
    #1;
    checkOutput("rm_ro_off", ro_rstn, 0);
    checkOutput("rm_valid", result_valid, 0);
    checkOutput("rm_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rm_idle", busy, 0);
    checkOutput("rm_no_result", results_seen, base);
    pushScan();
    pulseStart(1'b0);
    @(negedge clk);
    checkOutput("rm_restart_idx0", ro_rstn, 2'b01);
    waitIdle(400);
    checkOutput("t5_sb_drained", sb.size(), 0);
    checkOutput("t5_results", results_seen, base + 2);

    // Extra start while busy
    base = results_seen;
    pushScan();
    pulseStart(1'b0);
    repeat (30) @(posedge clk);
    pulseStart(1'b0);
    waitIdle(400);
    repeat (5) @(negedge clk);
    checkOutput("t6_sb_drained", sb.size(), 0);
    checkOutput("t6_results", results_seen, base + 2);
    checkOutput("t6_still_idle", busy, 0);

    checkOutput("onehot_ro_rstn", onehot_viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
